linescanner_capture_sequencer: RTL and testbench

LINESCANNER_CAPTURE_SEQUENCER -- requirements
Module: linescanner_capture_sequencer

---
 rtl/linescanner_capture_sequencer.sv | 178 +++++++++++++++++
 tb/tb_linescanner_capture_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/linescanner_capture_sequencer.sv
// -----------------------------------------------------------------------------
// linescanner_capture_sequencer
//
// Purpose:
//   Drives the line-scan sensor exposure handshake and captures the sensor's
//   pixel stream.
//   - Exposure: rst_cvc low -> rst_cds low -> wait for ADC done -> sample
//     strobe -> release both resets.
//   - Capture: this path runs on its own, regardless of the sequencer state.
//     Pixels are registered while lval is high and tagged with their index
//     in the line. Line ends are counted, and a wrong line length is flagged.
//
// Ports:
//   main_clock_source  clock
//   n_reset            synchronous active-low reset
//   enable             sequence request
//   one_shot           1: one sequence per enable rising edge; 0: continuous
//   end_adc            sensor ADC-done
//   lval, data         sensor line-valid and pixel value
//   rst_cvc, rst_cds   sensor resets, active-low pulses
//   sample             sensor sample strobe
//   busy               sequence in progress
//   pixel_data         registered pixel value
//   pixel_valid        qualifier for pixel_data and pixel_index
//   pixel_index        index of pixel_data within its line
//   line_done          one-cycle pulse at the end of each line
//   line_count         number of completed lines (wraps)
//   length_error       sticky flag: a line ended with the wrong pixel count
// -----------------------------------------------------------------------------
module linescanner_capture_sequencer #(
  parameter int DATA_WIDTH         = 8,
  parameter int CLKS_PER_US        = 48,
  parameter int CDS_TO_SAMPLE_CLKS = 7,
  parameter int SAMPLE_HOLD_CLKS   = 48,
  parameter int RELEASE_CLKS       = 6,
  parameter int PIXELS_PER_LINE    = 1024,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                  main_clock_source,
  input  logic                  n_reset,
  input  logic                  enable,
  input  logic                  one_shot,
  input  logic                  end_adc,
  input  logic                  lval,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  rst_cvc,
  output logic                  rst_cds,
  output logic                  sample,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] pixel_data,
  output logic                  pixel_valid,
  output logic [CNT_WIDTH-1:0]  pixel_index,
  output logic                  line_done,
  output logic [CNT_WIDTH-1:0]  line_count,
  output logic                  length_error
);

  typedef enum logic [2:0] {
    IDLE, CVC_LOW, CDS_LOW, WAIT_ADC, SAMPLE_HI, SAMPLE_LO, RELEASE
  } state_t;

  // Each timed state leaves when the counter reaches its last cycle.
  localparam logic [CNT_WIDTH-1:0] CVC_LAST    = CNT_WIDTH'(CLKS_PER_US - 1);
  localparam logic [CNT_WIDTH-1:0] CDS_LAST    = CNT_WIDTH'(CDS_TO_SAMPLE_CLKS - 1);
  localparam logic [CNT_WIDTH-1:0] SAMPLE_LAST = CNT_WIDTH'(SAMPLE_HOLD_CLKS - 1);
  localparam logic [CNT_WIDTH-1:0] REL_LAST    = CNT_WIDTH'(RELEASE_CLKS - 1);
  localparam logic [CNT_WIDTH-1:0] PIX_EXPECT  = CNT_WIDTH'(PIXELS_PER_LINE);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
  logic                   enable_prev_q;
  logic                   rst_cvc_q, rst_cvc_d;
  logic                   rst_cds_q, rst_cds_d;
  logic                   sample_q, sample_d;
  logic                   busy_q, busy_d;
  logic                   start;

  // ---------------- sequencer: next state and outputs ----------------
  always_comb begin
    state_d = state_q;
    start   = enable && (!one_shot || !enable_prev_q);

    case (state_q)
      IDLE:      if (start)                     state_d = CVC_LOW;
      CVC_LOW:   if (wait_cnt_q == CVC_LAST)    state_d = CDS_LOW;
      CDS_LOW:   if (wait_cnt_q == CDS_LAST)    state_d = WAIT_ADC;
      WAIT_ADC:  if (end_adc)                   state_d = SAMPLE_HI;
      SAMPLE_HI: if (wait_cnt_q == SAMPLE_LAST) state_d = SAMPLE_LO;
      SAMPLE_LO: if (wait_cnt_q == REL_LAST)    state_d = RELEASE;
      RELEASE:                                  state_d = IDLE;
      default:                                  state_d = IDLE;
    endcase

    // The shared wait counter restarts at zero whenever the state changes.
    wait_cnt_d = (state_d != state_q) ? '0 : wait_cnt_q + CNT_WIDTH'(1);

    // Outputs are decoded from the next state and then registered. This
    // way each output changes on the same edge that enters its state.
    rst_cvc_d = !(state_d inside {CVC_LOW, CDS_LOW, WAIT_ADC, SAMPLE_HI, SAMPLE_LO});
    rst_cds_d = !(state_d inside {CDS_LOW, WAIT_ADC, SAMPLE_HI, SAMPLE_LO});
    sample_d  = (state_d == SAMPLE_HI);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge main_clock_source) begin
    if (!n_reset) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      enable_prev_q <= 1'b0;
      rst_cvc_q     <= 1'b1;
      rst_cds_q     <= 1'b1;
      sample_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      enable_prev_q <= enable;
      rst_cvc_q     <= rst_cvc_d;
      rst_cds_q     <= rst_cds_d;
      sample_q      <= sample_d;
      busy_q        <= busy_d;
    end
  end

  // ---------------- pixel capture ----------------
  logic [CNT_WIDTH-1:0]  line_cnt_q;   // pixels seen so far in the current line
  logic                  lval_prev_q;
  logic [DATA_WIDTH-1:0] pixel_data_q;
  logic [CNT_WIDTH-1:0]  pixel_index_q;
  logic                  pixel_valid_q;
  logic                  line_done_q;
  logic [CNT_WIDTH-1:0]  line_count_q;
  logic                  length_error_q;

  always_ff @(posedge main_clock_source) begin
    if (!n_reset) begin
      line_cnt_q     <= '0;
      lval_prev_q    <= 1'b0;
      pixel_data_q   <= '0;
      pixel_index_q  <= '0;
      pixel_valid_q  <= 1'b0;
      line_done_q    <= 1'b0;
      line_count_q   <= '0;
      length_error_q <= 1'b0;
    end else begin
      lval_prev_q   <= lval;
      pixel_valid_q <= 1'b0;
      line_done_q   <= 1'b0;
      if (lval) begin
        pixel_data_q  <= data;
        pixel_index_q <= line_cnt_q;
        pixel_valid_q <= (line_cnt_q < PIX_EXPECT);
        // Saturate rather than wrap, so that a runaway line can never look
        // valid again or look correctly sized.
        if (line_cnt_q != '1)
          line_cnt_q <= line_cnt_q + CNT_WIDTH'(1);
      end else if (lval_prev_q) begin
        line_done_q  <= 1'b1;
        line_count_q <= line_count_q + CNT_WIDTH'(1);
        line_cnt_q   <= '0;
        if (line_cnt_q != PIX_EXPECT)
          length_error_q <= 1'b1;
      end
    end
  end

  assign rst_cvc      = rst_cvc_q;
  assign rst_cds      = rst_cds_q;
  assign sample       = sample_q;
  assign busy         = busy_q;
  assign pixel_data   = pixel_data_q;
  assign pixel_valid  = pixel_valid_q;
  assign pixel_index  = pixel_index_q;
  assign line_done    = line_done_q;
  assign line_count   = line_count_q;
  assign length_error = length_error_q;

endmodule

// File: tb/tb_linescanner_capture_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for linescanner_capture_sequencer.
// The stimulus queues the expected sensor-control edges, pixels and line ends.
// A negedge monitor pops an entry each time the DUT presents an edge, a pixel
// or a line_done, and compares it with the DUT output.
// -----------------------------------------------------------------------------
module tb_linescanner_capture_sequencer;

  localparam int DW   = 8;
  localparam int CLKS = 48;
  localparam int CDS  = 7;
  localparam int SH   = 48;
  localparam int REL  = 6;
  localparam int PIX  = 1024;
  localparam int CW   = 16;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic enable = 1'b0;
  logic one_shot = 1'b0;
  logic end_adc = 1'b1;
  logic lval = 1'b0;
  logic [DW-1:0] data = '0;
  logic rst_cvc, rst_cds, sample, busy, pixel_valid, line_done, length_error;
  logic [DW-1:0] pixel_data;
  logic [CW-1:0] pixel_index, line_count;

  linescanner_capture_sequencer #(
    .DATA_WIDTH(DW), .CLKS_PER_US(CLKS), .CDS_TO_SAMPLE_CLKS(CDS),
    .SAMPLE_HOLD_CLKS(SH), .RELEASE_CLKS(REL), .PIXELS_PER_LINE(PIX),
    .CNT_WIDTH(CW)
  ) dut (
    .main_clock_source(clk), .n_reset(n_reset), .enable(enable),
    .one_shot(one_shot), .end_adc(end_adc), .lval(lval), .data(data),
    .rst_cvc(rst_cvc), .rst_cds(rst_cds), .sample(sample), .busy(busy),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_index(pixel_index), .line_done(line_done),
    .line_count(line_count), .length_error(length_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // ---------------- reference model: expected queues ----------------
  // Signal codes: 0 = rst_cvc, 1 = rst_cds, 2 = sample.
  // A delta of -1 means the interval since the previous edge is not checked.
  typedef struct { int sig; bit val; int delta; } ev_t;
  ev_t ev_q[$];
  logic [DW+CW-1:0] pix_q[$];     // {data, index}
  logic [CW:0]      line_q[$];    // {length_error, line_count}
  int  m_lines = 0;
  bit  m_err   = 1'b0;

  task automatic push_ev(int s, bit v, int d);
    ev_t e;
    e.sig = s; e.val = v; e.delta = d;
    ev_q.push_back(e);
  endtask

  // One full exposure sequence, as sensor-control edges and their spacing.
  task automatic push_seq(int first_delta, int sample_delta);
    push_ev(0, 1'b0, first_delta);
    push_ev(1, 1'b0, CLKS);
    push_ev(2, 1'b1, sample_delta);
    push_ev(2, 1'b0, SH);
    push_ev(0, 1'b1, REL);
    push_ev(1, 1'b1, 0);
  endtask

  task automatic drive_line(int len, bit idx_data, int gap);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      lval = 1'b1;
      data = idx_data ? DW'(i) : DW'($urandom);
      if (i < PIX) pix_q.push_back({data, CW'(i)});
    end
    @(negedge clk);
    lval = 1'b0;
    m_lines = (m_lines + 1) % (1 << CW);
    if (len != PIX) m_err = 1'b1;
    line_q.push_back({m_err, CW'(m_lines)});
    repeat (gap - 1) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit   mon_en = 1'b0;
  logic [2:0] prev_ctl;
  int   last_ev = 0;
  int   starts = 0;
  ev_t  mon_e;
  logic [DW+CW-1:0] mon_p;
  logic [CW:0]      mon_l;

  always @(negedge clk) begin
    if (mon_en) begin
      logic [2:0] cur;
      cur = {sample, rst_cds, rst_cvc};
      for (int s = 0; s < 3; s++) begin
        if (cur[s] !== prev_ctl[s]) begin
          if (ev_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ctl_edge: sig %0d got %b expected no edge", s, cur[s]);
          end else begin
            mon_e = ev_q.pop_front();
            chk("ctl_edge_sig", s, mon_e.sig);
            chk("ctl_edge_val", cur[s], mon_e.val);
            if (mon_e.delta >= 0) chk("ctl_edge_delta", cyc - last_ev, mon_e.delta);
          end
          last_ev = cyc;
          if (s == 0 && cur[s] == 1'b0) starts++;
          prev_ctl[s] = cur[s];
        end
      end
      if (pixel_valid === 1'b1) begin
        if (pix_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel: got idx %0d expected none", pixel_index);
        end else begin
          mon_p = pix_q.pop_front();
          chk("pixel_data_index", {pixel_data, pixel_index}, mon_p);
        end
      end
      if (line_done === 1'b1) begin
        if (line_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_line_done: got count %0d expected none", line_count);
        end else begin
          mon_l = line_q.pop_front();
          chk("line_err_count", {length_error, line_count}, mon_l);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    int bad;
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rst_cvc", rst_cvc, 1);
    chk("rst_rst_cds", rst_cds, 1);
    chk("rst_sample", sample, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_pixel_data", pixel_data, 0);
    chk("rst_pixel_index", pixel_index, 0);
    chk("rst_line_count", line_count, 0);
    chk("rst_length_error", length_error, 0);
    prev_ctl = 3'b011;
    last_ev  = cyc;
    mon_en   = 1'b1;
    n_reset  = 1'b1;

    // Continuous mode: three back-to-back sequences, then drop enable mid-sequence.
    s0 = starts;
    push_seq(-1, CDS + 1);
    push_seq(2, CDS + 1);
    push_seq(2, CDS + 1);
    one_shot = 1'b0; end_adc = 1'b1; enable = 1'b1;
    for (int i = 0; i < 1000 && starts < s0 + 3; i++) @(negedge clk);
    chk("cont_three_starts", starts, s0 + 3);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    chk("cont_no_extra_start", starts, s0 + 3);
    chk("cont_events_drained", ev_q.size(), 0);
    chk("cont_busy_idle", busy, 0);

    // One-shot mode with enable held high; pixel lines run concurrently.
    one_shot = 1'b1;
    s0 = starts;
    push_seq(-1, CDS + 1);
    enable = 1'b1;
    fork
      begin
        repeat (5000) @(negedge clk);
      end
      begin
        drive_line(PIX, 1'b1, 5);
        drive_line(1030, 1'b0, 3);
        for (int k = 0; k < 4; k++) drive_line(int'($urandom_range(1, 60)), 1'b0, 1);
        drive_line(PIX, 1'b0, 1);
        drive_line(PIX, 1'b1, 4);
      end
    join
    chk("oneshot_single_seq", starts, s0 + 1);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    push_seq(-1, CDS + 1);
    for (int i = 0; i < 10 && starts < s0 + 2; i++) @(negedge clk);
    chk("oneshot_rearm_start", starts, s0 + 2);
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    chk("oneshot_done", busy, 0);
    chk("oneshot_events_drained", ev_q.size(), 0);
    enable = 1'b0;
    @(negedge clk);

    // ADC stall: end_adc held low in WAIT_ADC.
    end_adc = 1'b0;
    push_ev(0, 1'b0, -1); push_ev(1, 1'b0, CLKS); push_ev(2, 1'b1, -1);
    push_ev(2, 1'b0, SH); push_ev(0, 1'b1, REL); push_ev(1, 1'b1, 0);
    enable = 1'b1;
    for (int i = 0; i < 200 && rst_cds !== 1'b0; i++) @(negedge clk);
    chk("adc_cds_low", rst_cds, 0);
    enable = 1'b0;
    repeat (CDS + 2) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sample !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("adc_stall_bad_cycles", bad, 0);
    end_adc = 1'b1;
    @(negedge clk);
    chk("adc_sample_next_edge", sample, 1);
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
    chk("adc_done", busy, 0);
    chk("adc_events_drained", ev_q.size(), 0);

    // Reset during SAMPLE_HI.
    s0 = starts;
    push_ev(0, 1'b0, -1); push_ev(1, 1'b0, CLKS); push_ev(2, 1'b1, CDS + 1);
    push_ev(0, 1'b1, -1); push_ev(1, 1'b1, 0); push_ev(2, 1'b0, 0);
    enable = 1'b1;
    for (int i = 0; i < 200 && sample !== 1'b1; i++) @(negedge clk);
    chk("rsthi_sample_high", sample, 1);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    chk("rsthi_sample", sample, 0);
    chk("rsthi_rst_cvc", rst_cvc, 1);
    chk("rsthi_rst_cds", rst_cds, 1);
    chk("rsthi_busy", busy, 0);
    chk("rsthi_line_count", line_count, 0);
    chk("rsthi_length_error", length_error, 0);
    m_lines = 0;
    m_err   = 1'b0;
    n_reset = 1'b1;
    repeat (60) @(negedge clk);
    chk("rsthi_no_resume", starts, s0 + 1);
    chk("rsthi_events_drained", ev_q.size(), 0);

    // Fresh sequence after reset has full timing; one good line after reset.
    push_seq(-1, CDS + 1);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    drive_line(PIX, 1'b1, 3);
    for (int i = 0; i < 300 && busy !== 1'b0; i++) @(negedge clk);
    chk("post_rst_seq_done", busy, 0);

    repeat (5) @(negedge clk);
    chk("final_events_drained", ev_q.size(), 0);
    chk("final_pixels_drained", pix_q.size(), 0);
    chk("final_lines_drained", line_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
